// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: read-side sequencer for the 32x32 CPU register file.
// On a start pulse it walks rf_readnum from FIRST_REG to LAST_REG, captures
// each register's combinational read data and streams it over valid/ready
// together with its index. rf_hold stays high for the whole dump so the core
// cannot write the register file mid-dump.
//
// Optional feature (macro REGDUMP_CHECKSUM_EN): an XOR accumulator over all
// accepted words, sent as one extra beat (dump_csum=1, dump_last=1) after the
// final register beat.
//
// Ports:
//   clock        system clock, all state updates on posedge
//   reset        synchronous, active-low
//   start        one-cycle dump request, ignored unless idle
//   abort        cancel the dump, return to idle without done
//   rf_readnum   register-file read address (registered)
//   rf_data_out  register-file read data (combinational from rf_readnum)
//   rf_hold      high while a dump is active
//   dump_valid   output word valid
//   dump_ready   consumer accepts word when valid && ready at posedge
//   dump_index   register index of the current word
//   dump_data    captured register value
//   dump_last    final beat of the dump
//   dump_csum    checksum beat marker (0 without REGDUMP_CHECKSUM_EN)
//   busy         sequencer not idle
//   done         one-cycle pulse after the final beat is accepted
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rf_readnum,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              rf_hold,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [4:0]        dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              dump_csum,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = 5;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   readnum_d;
    logic               active_d;
    logic               valid_d;
    logic [IDX_W-1:0]   index_d;
    logic [DATA_W-1:0]  data_d;
    logic               last_d;
    logic               done_d;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               csum_d;
`endif

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= FIRST_IDX;
            rf_readnum <= '0;
            rf_hold    <= 1'b0;
            busy       <= 1'b0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            dump_data  <= '0;
            dump_last  <= 1'b0;
            done       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q      <= '0;
            dump_csum  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rf_readnum <= readnum_d;
            rf_hold    <= active_d;
            busy       <= active_d;
            dump_valid <= valid_d;
            dump_index <= index_d;
            dump_data  <= data_d;
            dump_last  <= last_d;
            done       <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
            acc_q      <= acc_d;
            dump_csum  <= csum_d;
`endif
        end
    end

`ifndef REGDUMP_CHECKSUM_EN
    assign dump_csum = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = dump_valid;
        index_d = dump_index;
        data_d  = dump_data;
        last_d  = dump_last;
        done_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d   = acc_q;
        csum_d  = dump_csum;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    idx_d   = FIRST_IDX;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            // rf_readnum already equals idx; capture the combinational read data
            READ: begin
                state_d = SEND;
                valid_d = 1'b1;
                index_d = idx_q;
                data_d  = rf_data_out;
`ifdef REGDUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = 1'b0;
`else
                last_d  = (idx_q == LAST_IDX);
`endif
            end
            SEND: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = acc_q ^ dump_data;
`endif
                    // Terminate on LAST_IDX rather than incrementing so idx never wraps
                    if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                        state_d = CSUM;
                        valid_d = 1'b1;
                        data_d  = acc_q ^ dump_data;
                        index_d = '0;
                        last_d  = 1'b1;
                        csum_d  = 1'b1;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    csum_d  = 1'b0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
            default: begin
                state_d = IDLE;
                idx_d   = FIRST_IDX;
            end
        endcase

        // Abort wins over start and dump_ready; all outputs return to reset values
        if (abort) begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
            valid_d = 1'b0;
            index_d = '0;
            data_d  = '0;
            last_d  = 1'b0;
            done_d  = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum_d  = 1'b0;
`endif
        end

        active_d  = (state_d != IDLE);
        readnum_d = active_d ? idx_d : '0;
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed bench for regfile_dump_reader.
// A behavioural register file returns 0 for x0 and rf_base+i otherwise.
// A second instance with FIRST_REG == LAST_REG == 31 covers the single-beat dump.
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
    localparam int NBEATS   = 33;
    localparam int DONE_CYC = 66;
    localparam bit CSUM_ON  = 1'b1;
`else
    localparam int NBEATS   = 32;
    localparam int DONE_CYC = 65;
    localparam bit CSUM_ON  = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dump_ready = 1'b0;
    logic [4:0]  rf_readnum;
    logic [31:0] rf_data_out;
    logic        rf_hold, dump_valid, dump_last, dump_csum, busy, done;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;

    logic        s_start = 1'b0;
    logic        s_abort = 1'b0;
    logic        s_ready = 1'b0;
    logic [4:0]  s_readnum;
    logic [31:0] s_data_out;
    logic        s_hold, s_valid, s_last, s_csum, s_busy, s_done;
    logic [4:0]  s_index;
    logic [31:0] s_data;

    logic [31:0] rf_base = 32'hA5A5_0000;
    int          vectors = 0;
    int          miscompares = 0;
    bit          found;

    always #5 clock = ~clock;

    // Behavioural register file: x0 reads as zero
    always_comb rf_data_out = (rf_readnum == 5'd0) ? 32'h0 : rf_base + 32'(rf_readnum);
    always_comb s_data_out  = (s_readnum == 5'd0) ? 32'h0 : rf_base + 32'(s_readnum);

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out), .rf_hold(rf_hold),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index),
        .dump_data(dump_data), .dump_last(dump_last), .dump_csum(dump_csum),
        .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_REG(31), .LAST_REG(31), .DATA_W(32)) dut_single (
        .clock(clock), .reset(reset), .start(s_start), .abort(s_abort),
        .rf_readnum(s_readnum), .rf_data_out(s_data_out), .rf_hold(s_hold),
        .dump_valid(s_valid), .dump_ready(s_ready), .dump_index(s_index),
        .dump_data(s_data), .dump_last(s_last), .dump_csum(s_csum),
        .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1; mode 2: stray start at index 10
    task automatic run_dump(input int mode, input logic [31:0] csum_want, input string name);
        int          cyc;
        int          exp_idx;
        int          done_cyc;
        bit          held;
        bit          injected;
        logic [31:0] hdata;
        logic [4:0]  hidx;
        logic [31:0] wdata;
        logic [3:0]  pat;
        pat = 4'b1001;
        exp_idx = 0;
        done_cyc = -1;
        held = 1'b0;
        injected = 1'b0;
        hdata = '0;
        hidx = '0;
        dump_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({name, "_busy_on_start"}, 32'(busy), 32'd1);
        check({name, "_readnum_first"}, 32'(rf_readnum), 32'd0);
        while (cyc < 400) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            check({name, "_hold"}, 32'(rf_hold), 32'd1);
            if (mode == 1) dump_ready = pat[2'(cyc)];
            else           dump_ready = 1'b1;
            if (dump_valid) begin
                if (held) begin
                    check({name, "_stable_data"}, dump_data, hdata);
                    check({name, "_stable_index"}, 32'(dump_index), 32'(hidx));
                end else if (exp_idx >= 32) begin
                    check({name, "_csum_index"}, 32'(dump_index), 32'd0);
                    check({name, "_csum_data"}, dump_data, csum_want);
                    check({name, "_csum_last"}, 32'(dump_last), 32'd1);
                    check({name, "_csum_flag"}, 32'(dump_csum), 32'd1);
                end else begin
                    wdata = (exp_idx == 0) ? 32'h0 : rf_base + 32'(exp_idx);
                    check({name, "_index"}, 32'(dump_index), 32'(exp_idx));
                    check({name, "_data"}, dump_data, wdata);
                    check({name, "_last"}, 32'(dump_last), 32'((exp_idx == 31) && !CSUM_ON));
                    check({name, "_csum_zero"}, 32'(dump_csum), 32'd0);
                end
                if (mode == 2 && !injected && dump_index == 5'd10) begin
                    start = 1'b1;
                    injected = 1'b1;
                end
                if (dump_ready) begin
                    exp_idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hdata = dump_data;
                    hidx = dump_index;
                end
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check({name, "_beats"}, 32'(exp_idx), 32'(NBEATS));
        if (mode == 1) check({name, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
        else           check({name, "_done_cycle"}, 32'(done_cyc), 32'(DONE_CYC));
        tick();
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_busy_drop"}, 32'(busy), 32'd0);
        check({name, "_hold_drop"}, 32'(rf_hold), 32'd0);
    endtask

    initial begin
        // Reset held two cycles with start high
        start = 1'b1;
        tick();
        tick();
        check("rst_readnum", 32'(rf_readnum), 32'd0);
        check("rst_hold", 32'(rf_hold), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_index", 32'(dump_index), 32'd0);
        check("rst_data", dump_data, 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_csum", 32'(dump_csum), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        reset = 1'b1;
        tick();
        check("idle_after_release", 32'(busy), 32'd0);

        // Full dump, ready high; checksum over A5A50000+i (i=1..31) is A5A50000
        run_dump(0, 32'hA5A5_0000, "full");
        // Backpressure
        run_dump(1, 32'hA5A5_0000, "bp");
        // Start while busy is ignored
        run_dump(2, 32'hA5A5_0000, "ign_start");

        // Abort during SEND of index 5, ready also high
        dump_ready = 1'b1;
        found = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dump_valid && dump_index == 5'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("abort_reached_idx5", 32'(found), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_hold", 32'(rf_hold), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_readnum", 32'(rf_readnum), 32'd0);
        check("abort_data", dump_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_stays_idle", 32'(busy), 32'd0);
        end

        // Start and abort together while idle: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", 32'(busy), 32'd0);
        tick();
        check("start_abort_idle_hold", 32'(rf_hold), 32'd0);

        // x(i)=i after abort: restarts from index 0; XOR of 0..31 is 0
        rf_base = 32'h0;
        run_dump(0, 32'h0, "xi");

        // Single-beat dump on the FIRST_REG == LAST_REG instance
        rf_base = 32'h1234_0000;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("single_busy", 32'(s_busy), 32'd1);
        tick();
        check("single_valid", 32'(s_valid), 32'd1);
        check("single_index", 32'(s_index), 32'd31);
        check("single_data", s_data, 32'h1234_001F);
        check("single_last", 32'(s_last), 32'(!CSUM_ON));
        s_ready = 1'b1;
        tick();
`ifdef REGDUMP_CHECKSUM_EN
        check("single_csum_flag", 32'(s_csum), 32'd1);
        check("single_csum_last", 32'(s_last), 32'd1);
        check("single_csum_data", s_data, 32'h1234_001F);
        tick();
`endif
        s_ready = 1'b0;
        check("single_done", 32'(s_done), 32'd1);
        check("single_valid_drop", 32'(s_valid), 32'd0);
        tick();
        check("single_done_drop", 32'(s_done), 32'd0);
        check("single_busy_drop", 32'(s_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
